// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared 4-bit group generate/propagate helpers and types
package cla_pkg;

  localparam int GROUP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic grp_prop(input logic [3:0] p);
    return &p;
  endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// rtl/cla_lookahead4.sv - flat 4-input carry lookahead over G/P pairs
module cla_lookahead4
  import cla_pkg::*;
(
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c_i,
  output logic [4:1] c_o,
  output logic       g_o,
  output logic       p_o
);

  assign g_o = grp_gen(g_i, p_i);
  assign p_o = grp_prop(p_i);

  // every carry is a two-level sum of products of g/p/c_i, no internal chain
  assign c_o[1] = g_i[0] | (p_i[0] & c_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign c_o[4] = g_o | (p_o & c_i);

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined carry-lookahead adder with valid/ready
module cla_pipe_adder
  import cla_pkg::gp_t;
  import cla_pkg::grp_gen;
  import cla_pkg::grp_prop;
#(
  parameter int WIDTH = 32,  // multiple of GROUP, 8..64
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_gg,
  output logic             out_gp
);

  localparam int NG  = WIDTH / GROUP;   // lookahead groups
  localparam int NSG = (NG + 3) / 4;    // 4-group super-groups
  localparam int NGP = NSG * 4;         // groups padded to whole super-groups

  logic adv1, adv2;

  logic             s1_valid_q;
  logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
  gp_t  [NG-1:0]    grp_d, grp_q;
  logic             cin_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, gg_d, gg_q, gp_d, gp_q;

  // a stage moves when its downstream slot is empty or being drained
  assign adv2     = !out_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;

  // stage 1: per-bit and per-group generate/propagate from the operands
  always_comb begin
    p_d   = in_a ^ in_b;
    g_d   = in_a & in_b;
    grp_d = '0;
    for (int k = 0; k < NG; k++) begin
      grp_d[k].g = grp_gen(g_d[GROUP*k +: 4], p_d[GROUP*k +: 4]);
      grp_d[k].p = grp_prop(p_d[GROUP*k +: 4]);
    end
  end

  // stage 1 register: loads only on an accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      grp_q      <= '0;
      cin_q      <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        p_q   <= p_d;
        g_q   <= g_d;
        grp_q <= grp_d;
        cin_q <= in_cin;
      end
    end
  end

  // pad unused group slots as transparent (G=0, P=1) so whole-word terms stay exact
  logic [NGP-1:0] gpad, ppad;
  logic [NSG-1:0] sg_g, sg_p;
  logic [3:0]     sg_g_pad, sg_p_pad;
  logic [4:0]     c_sg;
  logic [NGP:0]   c_grp;
  logic           word_g, word_p;

  // gather group terms into padded vectors for the lookahead tree
  always_comb begin
    gpad     = '0;
    ppad     = '1;
    sg_g_pad = '0;
    sg_p_pad = '1;
    for (int k = 0; k < NG; k++) begin
      gpad[k] = grp_q[k].g;
      ppad[k] = grp_q[k].p;
    end
    for (int s = 0; s < NSG; s++) begin
      sg_g_pad[s] = sg_g[s];
      sg_p_pad[s] = sg_p[s];
    end
  end

  assign c_sg[0]  = cin_q;
  assign c_grp[0] = cin_q;

  // top level resolves super-group carries directly from cin
  cla_lookahead4 u_top (
    .g_i (sg_g_pad),
    .p_i (sg_p_pad),
    .c_i (cin_q),
    .c_o (c_sg[4:1]),
    .g_o (word_g),
    .p_o (word_p)
  );

  // second level expands each super-group carry into its four group carries
  for (genvar s = 0; s < NSG; s++) begin : g_sg
    cla_lookahead4 u_grp (
      .g_i (gpad[4*s +: 4]),
      .p_i (ppad[4*s +: 4]),
      .c_i (c_sg[s]),
      .c_o (c_grp[4*s+1 +: 4]),
      .g_o (sg_g[s]),
      .p_o (sg_p[s])
    );
  end

  logic [WIDTH-1:0] c;
  logic [3:0]       gs, ps;
  logic             cg;

  // in-group carries, each flattened against its group carry-in
  always_comb begin
    c  = '0;
    gs = '0;
    ps = '0;
    cg = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gs = g_q[GROUP*k +: 4];
      ps = p_q[GROUP*k +: 4];
      cg = c_grp[k];
      c[GROUP*k]   = cg;
      c[GROUP*k+1] = gs[0] | (ps[0] & cg);
      c[GROUP*k+2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & cg);
      c[GROUP*k+3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                   | (ps[2] & ps[1] & ps[0] & cg);
    end
  end

  assign sum_d  = p_q ^ c;
  assign cout_d = c_sg[4];
  assign ovf_d  = c_grp[NG] ^ c[WIDTH-1];
  assign gg_d   = word_g;
  assign gp_d   = word_p;

  // carries beyond the last real group duplicate the word carry
  logic unused_carries;
  assign unused_carries = ^{c_sg, c_grp};

  // stage 2 / output register: holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      gg_q        <= 1'b0;
      gp_q        <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        gg_q   <= gg_d;
        gp_q   <= gp_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_gg    = gg_q;
  assign out_gp    = gp_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - table and scoreboard bench for cla_pipe_adder
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        gg;
    logic        gp;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf, out_gg, out_gp;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  res_t sb[$];
  vec_t tbl[10];

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_gg    (out_gg),
    .out_gp    (out_gp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
    res_t        r;
    logic [32:0] s, s0;
    s      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    s0     = {1'b0, a} + {1'b0, b};
    r.sum  = s[31:0];
    r.cout = s[32];
    r.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
    r.gg   = s0[32];
    r.gp   = &(a ^ b);
    return r;
  endfunction

  // retire side: pop and compare whenever a result transfers on the coming edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_beat: got sum %h with nothing expected", out_sum);
      end else begin
        chk("result", 64'({out_sum, out_cout, out_ovf, out_gg, out_gp}), 64'(sb.pop_front()));
      end
    end
  end

  // present one beat; called and returns just after a rising edge
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input res_t e);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (n >= 50) begin
          n_vec++;
          n_fail++;
          $display("FAIL drive_timeout: in_ready stuck at %b", in_ready);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [63:0] hold;
    int          t0;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, '{32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[9] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({out_sum, out_cout, out_ovf, out_gg, out_gp}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // ripple worst case with exact two-cycle latency
    drive(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].exp);
    chk("latency_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_two", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);
    repeat (4) @(posedge clk);
    #1;
    chk("table_drained", 64'(sb.size()), 64'd0);

    // back-to-back random stream
    t0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, model(ra, rb, rc));
    end
    chk("throughput_cycles", 64'(cyc - t0), 64'd1000);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // backpressure: two beats fill the pipe, third waits
    out_ready = 1'b0;
    ra = $urandom; rb = $urandom;
    drive(ra, rb, 1'b0, model(ra, rb, 1'b0));
    ra = $urandom; rb = $urandom;
    drive(ra, rb, 1'b1, model(ra, rb, 1'b1));
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    hold = 64'({out_sum, out_cout, out_ovf, out_gg, out_gp});
    ra = $urandom; rb = $urandom;
    in_valid = 1'b1;
    in_a     = ra;
    in_b     = rb;
    in_cin   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_output", 64'({out_sum, out_cout, out_ovf, out_gg, out_gp}), hold);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end

    // release: accept, shift and retire on one edge
    out_ready = 1'b1;
    drive(ra, rb, 1'b0, model(ra, rb, 1'b0));
    chk("simul_out_valid", 64'(out_valid), 64'd1);
    chk("simul_in_flight", 64'(sb.size()), 64'd2);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // asynchronous reset between edges drops everything in flight
    ra = $urandom; rb = $urandom;
    drive(ra, rb, 1'b1, model(ra, rb, 1'b1));
    ra = $urandom; rb = $urandom;
    drive(ra, rb, 1'b0, model(ra, rb, 1'b0));
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_outputs", 64'({out_sum, out_cout, out_ovf, out_gg, out_gp}), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("no_partial_result", 64'(out_valid), 64'd0);
    end
    drive(tbl[1].a, tbl[1].b, tbl[1].cin, tbl[1].exp);
    chk("post_reset_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("post_reset_latency", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Two-stage pipelined carry-lookahead adder with valid/ready handshake.
- Stage 1 forms per-bit generate/propagate and 4-bit group generate/propagate.
- Stage 2 runs the group-level lookahead, expands carries into each group, and forms sum, carry-out and signed overflow.
- Consumes operands from the datapath register file and feeds the same group G/P/carry structure as the team's combinational lookahead generator, now registered for timing closure.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of GROUP, minimum 8.
- GROUP, 4, bits per lookahead group (fixed 4 in this release).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 1 can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- out_cout  output  1  carry out of the MSB.
- out_ovf  output  1  signed overflow.
- out_gg  output  1  whole-word generate.
- out_gp  output  1  whole-word propagate.

Behaviour:
- Reset (async assert, sync deassert by the next edge):
  - s1_valid, s2_valid, out_valid = 0.
  - All data registers = 0.
  - in_ready = 1 once rst is low.
- Per-bit terms: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Group terms (k = group index, bits j = 0..3):
  - Gk = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Pk = p3p2p1p0.
- Stage 1 register holds p[WIDTH-1:0], g[WIDTH-1:0], G[], P[], cin and the operand MSBs.
- Stage 2 (combinational from the stage 1 register into the output register):
  - Group carries: c0 = cin; c(k+1) = Gk | Pk·ck.
  - These must be built as a lookahead over groups, no ripple chain across groups, up to 8 groups. Above 8 groups, use two levels of 4-group super-groups with the same G/P equations.
  - In-group carries: c(i+1) = g[i] | p[i]·c[i].
  - sum[i] = p[i] ^ c[i]; cout = c[WIDTH].
  - ovf = c[WIDTH] ^ c[WIDTH-1].
  - gg = whole-word G; gp = whole-word P (neither depends on cin).
- Latency: an accepted beat appears on out_valid exactly 2 cycles later if out_ready has been high throughout. Throughput is 1 beat per cycle.
- Handshake:
  - Transfer occurs when valid & ready are both high on a clock edge.
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, combinational from out_ready and state only; never from in_valid.
- Stall: while out_valid & !out_ready, out_sum, out_cout, out_ovf, out_gg and out_gp hold stable.
  - Stage 1 holds if it is occupied.
  - in_ready drops only when both stages are full.
- Simultaneous events: a full pipeline with out_ready = 1 and in_valid = 1 accepts a new beat, shifts stage 1 into stage 2, and retires the output, all on the same edge. No bubble is inserted.
- Pipeline bubbles propagate as valid = 0; data registers may update freely while invalid, but only when the stage advances.
- Reset mid-operation drops every in-flight beat; no partial result is emitted.
- Boundaries:
  - All-ones + 0 + cin = 1 produces sum 0, cout 1, and the full propagate chain completes within stage 2.
  - 0 + 0 produces gp = 0 and gg = 0.

Decomposition:
- Shared package cla_pkg holds:
  - GROUP constant 4.
  - Functions grp_gen(g, p) and grp_prop(p) returning 1-bit G/P for a 4-bit slice.
  - Typedef gp_t, a packed struct of {g, p}.
- One sub-module cla_lookahead4: combinational 4-input lookahead taking G[3:0], P[3:0] and c_in, producing c[4:1], G_out and P_out. Instantiated per super-group and at the top level in stage 2.

Test Plan:
- Ripple worst case: in_a = 0xFFFFFFFF, in_b = 0, cin = 1, out_ready = 1 -> 2 cycles later out_sum = 0x00000000, out_cout = 1, out_ovf = 0, out_gp = 1, out_gg = 0.
- Signed overflow: in_a = 0x7FFFFFFF, in_b = 0x00000001, cin = 0 -> out_sum = 0x80000000, out_ovf = 1, out_cout = 0.
- Back-to-back stream of 1000 random beats, out_ready = 1 -> one result per cycle, in order, each matching a reference model of A+B+cin.
- Backpressure: hold out_ready = 0 for 5 cycles while driving 3 beats -> in_ready drops after 2 accepted beats and the output holds stable. On release, beats retire in order with no loss or duplication.
- Simultaneous accept/retire: pipeline full, out_ready = 1, in_valid = 1 on the same edge -> all three transfers complete and the next cycle still shows 2 beats in flight.
- Async reset: assert rst mid-stream between clock edges -> out_valid and in-flight valids fall immediately and all outputs read 0. After deassert, the next accepted beat appears exactly 2 cycles later.
